// File: rtl/halt_drain_controller_pkg.sv
// Shared constants, HLT decode and FSM encoding for the halt/drain sequencer.
// The HALT_TIMEOUT_EN build macro enables the drain watchdog limit used by the top.
package halt_drain_controller_pkg;

    localparam int unsigned WORD_SIZE = 16;

    localparam logic [3:0]  OPCODE_RRR  = 4'd15;
    localparam logic [5:0]  FUNC_HLT    = 6'd29;
    localparam logic [15:0] WDOG_LIMIT  = 16'd1024;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StDrain   = 2'd1,
        StWaitMem = 2'd2,
        StHalted  = 2'd3
    } halt_state_e;

    function automatic logic is_hlt(input logic [3:0] opcode, input logic [5:0] func);
        return (opcode == OPCODE_RRR) && (func == FUNC_HLT);
    endfunction

endpackage

// File: rtl/halt_drain_controller_inflight_tracker.sv
// Saturating up/down count of instructions in flight; simultaneous up and down cancel,
// a down at zero and an up at MAX are both absorbed.
module inflight_tracker #(
    parameter int unsigned MAX   = 3,
    parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != CntMax)) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/halt_drain_controller.sv
// Stops fetch on HLT in ID, drains older instructions and memory, then flags halted.
// Define HALT_TIMEOUT_EN to add a watchdog that forces HALTED after a long drain.
module halt_drain_controller #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned PIPE_DEPTH = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [WORD_SIZE-1:0]              id_instr,
    input  logic                              id_valid,
    input  logic                              id_stall,
    input  logic                              retire_valid,
    input  logic                              mem_busy,
    output logic                              fetch_enable,
    output logic                              id_flush,
    output logic                              halt_pending,
    output logic                              is_halted,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]   inflight,
    output logic                              halt_timeout
);

    import halt_drain_controller_pkg::*;

    halt_state_e state_q, state_d;
    logic        flush_q, flush_d;
    logic        issue, issue_hlt, count_inc;

    // Only opcode and function fields matter for HLT decode.
    logic unused_instr_bits;
    assign unused_instr_bits = ^id_instr[11:6];

    assign issue     = id_valid && !id_stall;
    assign issue_hlt = issue && is_hlt(id_instr[15:12], id_instr[5:0]);
    assign count_inc = (state_q == StRun) && issue && !issue_hlt;

    inflight_tracker #(
        .MAX   (PIPE_DEPTH),
        .CNT_W ($clog2(PIPE_DEPTH + 1))
    ) u_inflight_tracker (
        .clk   (clk),
        .reset (reset),
        .inc   (count_inc),
        .dec   (retire_valid),
        .count (inflight)
    );

`ifdef HALT_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;
    logic        timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        case (state_q)
            StRun: begin
                if (issue_hlt) begin
                    state_d = StDrain;
                    flush_d = 1'b1;
                end
            end
            StDrain: begin
                if (inflight == '0) begin
                    state_d = StWaitMem;
                end
            end
            StWaitMem: begin
                if (!mem_busy) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StRun;
            end
        endcase
`ifdef HALT_TIMEOUT_EN
        wdog_d    = wdog_q;
        timeout_d = timeout_q;
        if ((state_q == StDrain) || (state_q == StWaitMem)) begin
            wdog_d = wdog_q + 16'd1;
            if (wdog_d >= WDOG_LIMIT) begin
                state_d   = StHalted;
                timeout_d = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
        end
    end

`ifdef HALT_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign halt_timeout = timeout_q;
`else
    assign halt_timeout = 1'b0;
`endif

    assign fetch_enable = (state_q == StRun);
    assign id_flush     = flush_q;
    assign halt_pending = (state_q == StDrain) || (state_q == StWaitMem);
    assign is_halted    = (state_q == StHalted);

endmodule

// File: tb/tb_halt_drain_controller.sv
// Directed plus randomized bench for halt_drain_controller against a behavioural model.
// Honours HALT_TIMEOUT_EN in the model so either build can be checked.
module tb_halt_drain_controller;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] id_instr = 16'h0000;
    logic        id_valid = 1'b0;
    logic        id_stall = 1'b0;
    logic        retire_valid = 1'b0;
    logic        mem_busy = 1'b0;
    logic        fetch_enable, id_flush, halt_pending, is_halted, halt_timeout;
    logic [1:0]  inflight;

    int checks = 0;
    int errors = 0;

    // Behavioural model: a halt request moves through accepted -> drained -> halted.
    int m_inflight;
    bit m_accepted, m_drained, m_halted, m_flush, m_timeout;
    int m_cycles_draining;

    localparam logic [15:0] HLT = 16'hF01D;
    localparam logic [15:0] ADD = 16'hF000;

    initial forever begin
        #5;
        if (clk_run) clk = ~clk;
    end

    halt_drain_controller #(
        .WORD_SIZE  (16),
        .PIPE_DEPTH (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_instr     (id_instr),
        .id_valid     (id_valid),
        .id_stall     (id_stall),
        .retire_valid (retire_valid),
        .mem_busy     (mem_busy),
        .fetch_enable (fetch_enable),
        .id_flush     (id_flush),
        .halt_pending (halt_pending),
        .is_halted    (is_halted),
        .inflight     (inflight),
        .halt_timeout (halt_timeout)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_inflight = 0;
        m_accepted = 0;
        m_drained = 0;
        m_halted = 0;
        m_flush = 0;
        m_timeout = 0;
        m_cycles_draining = 0;
    endfunction

    function automatic void model_edge();
        bit issue, hlt, inc;
        int prev;
        issue = id_valid && !id_stall;
        hlt = (id_instr[15:12] == 4'd15) && (id_instr[5:0] == 6'd29);
        prev = m_inflight;
        inc = !m_accepted && issue && !hlt;
        if (inc && !retire_valid) m_inflight = (prev < 3) ? prev + 1 : 3;
        else if (retire_valid && !inc) m_inflight = (prev > 0) ? prev - 1 : 0;
        m_flush = 0;
        if (!m_accepted) begin
            if (issue && hlt) begin
                m_accepted = 1;
                m_flush = 1;
            end
        end else if (!m_halted) begin
            if (!m_drained) begin
                if (prev == 0) m_drained = 1;
            end else if (!mem_busy) begin
                m_halted = 1;
            end
`ifdef HALT_TIMEOUT_EN
            m_cycles_draining++;
            if (m_cycles_draining >= 1024) begin
                m_halted = 1;
                m_timeout = 1;
            end
`endif
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".fetch_enable"}, 16'(fetch_enable), 16'(!m_accepted));
        chk({tag, ".id_flush"}, 16'(id_flush), 16'(m_flush));
        chk({tag, ".halt_pending"}, 16'(halt_pending), 16'(m_accepted && !m_halted));
        chk({tag, ".is_halted"}, 16'(is_halted), 16'(m_halted));
        chk({tag, ".inflight"}, 16'(inflight), 16'(m_inflight));
        chk({tag, ".halt_timeout"}, 16'(halt_timeout), 16'(m_timeout));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit v, input bit s, input logic [15:0] instr, input bit ret,
                         input bit mb);
        id_valid = v;
        id_stall = s;
        id_instr = instr;
        retire_valid = ret;
        mem_busy = mb;
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        model_reset();
        check_all(tag);
        reset = 1'b0;
        drive(0, 0, 16'h0000, 0, 0);
    endtask

    initial begin
        // Reset with the clock stopped.
        model_reset();
        reset = 1'b1;
        #2;
        check_all("rst_stopped");
        reset = 1'b0;
        clk_run = 1'b1;
        drive(1, 0, ADD, 0, 0);
        step("add1");
        chk("add_inflight", 16'(inflight), 16'd1);

        // Mid-cycle reset with the clock stopped again.
        clk_run = 1'b0;
        do_reset("rst_midcycle");
        clk_run = 1'b1;

        // Minimum latency HLT.
        drive(1, 0, HLT, 0, 0);
        step("minlat_e");
        chk("minlat_flush", 16'(id_flush), 16'd1);
        chk("minlat_fetch", 16'(fetch_enable), 16'd0);
        drive(0, 0, 16'h0000, 0, 0);
        step("minlat_e1");
        chk("minlat_flush_gone", 16'(id_flush), 16'd0);
        step("minlat_e2");
        chk("minlat_halted", 16'(is_halted), 16'd1);
        drive(1, 0, HLT, 1, 0);
        step("halted_sticky");

        // Three ADDs then HLT with retires trailing.
        do_reset("rst_drain3");
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, ADD, 0, 0);
            step("drain3_add");
        end
        drive(1, 0, HLT, 0, 0);
        step("drain3_hlt");
        chk("drain3_cnt", 16'(inflight), 16'd3);
        for (int k = 1; k <= 3; k++) begin
            drive(1, 0, ADD, 1, 0);
            step("drain3_ret");
            chk("drain3_cnt", 16'(inflight), 16'(3 - k));
        end
        drive(0, 0, 16'h0000, 0, 0);
        step("drain3_wm");
        chk("drain3_not_yet", 16'(is_halted), 16'd0);
        step("drain3_halt");
        chk("drain3_halted", 16'(is_halted), 16'd1);

        // Stalled HLT, then memory held busy.
        do_reset("rst_stall");
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, HLT, 0, 1);
            step("stall");
            chk("stall_pending", 16'(halt_pending), 16'd0);
        end
        drive(1, 0, HLT, 0, 1);
        step("stall_accept");
        chk("stall_accept_pending", 16'(halt_pending), 16'd1);
        for (int i = 0; i < 5; i++) begin
            step("membusy_hold");
            chk("membusy_not_halted", 16'(is_halted), 16'd0);
        end
        drive(0, 0, 16'h0000, 0, 0);
        step("membusy_release");
        chk("membusy_halted", 16'(is_halted), 16'd1);

        // Reset during memory hold.
        do_reset("rst_hold_pre");
        drive(1, 0, HLT, 0, 1);
        step("hold2_accept");
        drive(0, 0, 16'h0000, 0, 1);
        for (int i = 0; i < 3; i++) step("hold2");
        do_reset("rst_hold");
        chk("hold_reset_fetch", 16'(fetch_enable), 16'd1);
        step("after_hold_reset");

        // Drain that never completes: watchdog build halts, default build waits.
        do_reset("rst_wdog");
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, ADD, 0, 0);
            step("wdog_add");
        end
        drive(1, 0, HLT, 0, 0);
        step("wdog_hlt");
        drive(0, 0, 16'h0000, 0, 0);
        for (int i = 0; i < 1100; i++) step("wdog_wait");
`ifdef HALT_TIMEOUT_EN
        chk("wdog_timeout", 16'(halt_timeout), 16'd1);
        chk("wdog_halted", 16'(is_halted), 16'd1);
`else
        chk("wdog_still_pending", 16'(halt_pending), 16'd1);
        chk("wdog_no_timeout", 16'(halt_timeout), 16'd0);
`endif

        // Randomized episodes.
        for (int ep = 0; ep < 25; ep++) begin
            do_reset("rst_rand");
            for (int c = 0; c < 60; c++) begin
                logic [15:0] instr;
                instr = ($urandom_range(0, 9) == 0) ? HLT : 16'($urandom);
                drive(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, instr,
                      $urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)));
                step("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/halt_drain_controller.md
Name: halt_drain_controller

Overview:
Sequences CPU shutdown when a HLT instruction reaches the ID stage of the forwarding pipeline. It stops fetch and squashes the younger instruction in IF. It then waits for all older instructions to retire through WB and for the data-memory port to go idle. Only then does it assert the architectural halted flag to the testbench and top level. It sits beside the hazard unit and drives fetch enable and the IF/ID flush.

Parameters:
WORD_SIZE, 16, instruction width
PIPE_DEPTH, 3, maximum in-flight instructions beyond ID (EX, MEM, WB)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
id_instr  input  WORD_SIZE  instruction currently in ID
id_valid  input  1  ID holds a real (non-bubble) instruction
id_stall  input  1  hazard unit holds ID this cycle
retire_valid  input  1  WB completes one instruction this cycle
mem_busy  input  1  data-memory access outstanding
fetch_enable  output  1  PC update / IF fetch allowed
id_flush  output  1  one-cycle squash of the IF/ID register
halt_pending  output  1  HLT accepted, drain in progress
is_halted  output  1  sticky halted flag
inflight  output  $clog2(PIPE_DEPTH+1)  older instructions still in EX..WB
halt_timeout  output  1  drain watchdog fired (see Optional Feature)

Behaviour:
- Reset (async, any state): state=RUN, inflight=0, fetch_enable=1, id_flush=0, halt_pending=0, is_halted=0, halt_timeout=0.
- Issue event: id_valid && !id_stall. HLT = id_instr[15:12]==OPCODE_RRR && id_instr[5:0]==FUNC_HLT.
- inflight counter:
  - +1 on an issue of a non-HLT instruction in RUN.
  - -1 on retire_valid.
  - Issue and retire in the same cycle leave it unchanged.
  - Retire at 0 is ignored (stays 0).
  - An issue at PIPE_DEPTH saturates.
- FSM (registered, one transition per edge):
  - RUN: an issue of HLT moves to DRAIN. That same edge sets fetch_enable=0, halt_pending=1, and id_flush=1 for exactly one cycle. Issues with id_stall=1 are not accepted; stay in RUN.
  - DRAIN: no new issues are counted; retires continue to decrement. Move to WAIT_MEM on the first edge where registered inflight==0.
  - WAIT_MEM: move to HALTED on the first edge with mem_busy==0.
  - HALTED: is_halted=1, halt_pending=0, fetch_enable=0. Terminal until reset.
- Minimum latency: with an empty pipe and idle memory, HLT accepted at edge E gives is_halted=1 after edge E+2.
- A retire on the same edge as HLT acceptance is applied to inflight normally.
- The one-cycle mem_busy glitch rule: WAIT_MEM samples only at the edge; no filtering.
- Reset mid-DRAIN or mid-WAIT_MEM returns immediately to RUN with all outputs at reset values.
- A second HLT seen in ID while not in RUN is ignored.

Optional Feature:
Macro HALT_TIMEOUT_EN.
- Defined: a 16-bit watchdog counts cycles spent in DRAIN plus WAIT_MEM. On reaching 1024 it forces HALTED and sets halt_timeout=1, which is sticky until reset.
- Undefined: no watchdog logic; halt_timeout is tied 0.

Decomposition:
- Shared package: OPCODE_RRR (4'd15), FUNC_HLT (6'd29), WORD_SIZE, FSM state encoding (RUN, DRAIN, WAIT_MEM, HALTED), watchdog limit constant.
- One sub-module, inflight_tracker: the saturating up/down counter with simultaneous-event handling. It is reusable by the hazard unit.

Test Plan:
- Reset asserted mid-cycle with clk stopped -> all outputs at reset values immediately; release, then ADD issued -> inflight=1.
- Empty pipe, mem idle, HLT (0xF01D) issued at edge E -> id_flush=1 for one cycle after E; is_halted=1 after E+2; fetch_enable=0 from E on.
- Three ADDs issued back-to-back, then HLT; retires arrive at E+1..E+3 -> inflight 3,2,1,0; is_halted=1 two edges after the last retire.
- HLT presented with id_stall=1 for 2 cycles, then id_stall=0 -> acceptance only on the unstalled edge; halt_pending stays 0 before it.
- Pipe drained, mem_busy held 1 for 5 cycles -> state held in WAIT_MEM; is_halted rises one edge after mem_busy falls. Reset pulsed during the hold -> back to RUN, fetch_enable=1.
- HALT_TIMEOUT_EN defined, retire_valid never asserted after HLT with inflight=2 -> halt_timeout=1 and is_halted=1 after 1024 cycles. Macro undefined -> state stays in DRAIN indefinitely.
